// File: rtl/quadrature_pkg.sv
// quadrature_pkg: shared types and constants for the quadrature generator.
// Optional position tracking is enabled by QUADRATURE_GEN_POS_EN.
package quadrature_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALF1 = 2'd1,
    HALF2 = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [1:0] PHASE_00 = 2'b00;
  localparam logic [1:0] PHASE_11 = 2'b11;

  // Timer width for a reload value of cycles-1, never below one bit.
  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/quadrature_gen_step_timer.sv
// step_timer: reloadable down-counter pacing the a/b transitions.
// Reload value is STEP_CYCLES-1; expired flags a count of zero.
module step_timer
  import quadrature_pkg::*;
#(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int TW = timer_width(STEP_CYCLES);
  localparam logic [TW-1:0] RELOAD = TW'(STEP_CYCLES - 1);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Reload takes priority; otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/quadrature_gen.sv
// quadrature_gen: emits the a/b Gray sequence for a signed step command.
// Define QUADRATURE_GEN_POS_EN to build the emulated decoder position.
module quadrature_gen
  import quadrature_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int INCREMENT   = 1,
  parameter int STEP_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_count,
  output logic             cmd_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] position
);

  state_e state_q;
  state_e state_d;

  logic             dir_q;
  logic             dir_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] rem_d;
  logic             a_q;
  logic             a_d;
  logic             b_q;
  logic             b_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_exp;
  logic count_edge;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (tmr_load),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  // Next state, channel toggles and timer control.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rem_d      = rem_q;
    a_d        = a_q;
    b_d        = b_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    count_edge = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          dir_d    = cmd_dir;
          rem_d    = cmd_count;
          tmr_load = 1'b1;
          state_d  = (cmd_count != '0) ? HALF1 : DONE;
        end
      end
      HALF1: begin
        if (tmr_exp) begin
          if (dir_q == DIR_UP) begin
            a_d = ~a_q;
          end else begin
            b_d = ~b_q;
          end
          count_edge = 1'b1;
          tmr_load   = 1'b1;
          state_d    = HALF2;
        end else begin
          tmr_en = 1'b1;
        end
      end
      HALF2: begin
        if (tmr_exp) begin
          if (dir_q == DIR_UP) begin
            b_d = ~b_q;
          end else begin
            a_d = ~a_q;
          end
          rem_d    = rem_q - WIDTH'(1);
          tmr_load = 1'b1;
          state_d  = (rem_q == WIDTH'(1)) ? DONE : HALF1;
        end else begin
          tmr_en = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and channel registers; reset abandons any move at rest 00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_DOWN;
      rem_q      <= '0;
      {a_q, b_q} <= PHASE_00;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

`ifdef QUADRATURE_GEN_POS_EN
  localparam logic [WIDTH-1:0] INC = WIDTH'(INCREMENT);

  logic [WIDTH-1:0] pos_q;
  logic [WIDTH-1:0] pos_d;

  // Position follows the counting transition, wrapping mod 2^WIDTH.
  always_comb begin
    pos_d = pos_q;
    if (count_edge) begin
      pos_d = (dir_q == DIR_UP) ? pos_q + INC : pos_q - INC;
    end
  end

  // Position register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
    end else begin
      pos_q <= pos_d;
    end
  end

  assign position = pos_q;
`else
  logic unused_pos;
  assign unused_pos = ^{count_edge, INCREMENT};
  assign position   = '0;
`endif

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_quadrature_gen.sv
// tb_quadrature_gen: directed stimulus with a timeline model of a/b/position.
// Expected position depends on QUADRATURE_GEN_POS_EN.
module tb_quadrature_gen;

  localparam int W   = 4;
  localparam int INC = 1;
  localparam int S   = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_dir;
  logic [W-1:0] cmd_count;
  logic         cmd_ready;
  logic         a;
  logic         b;
  logic         busy;
  logic         done;
  logic [W-1:0] position;

  always #5 clk = ~clk;

  quadrature_gen #(
    .WIDTH      (W),
    .INCREMENT  (INC),
    .STEP_CYCLES(S)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_count(cmd_count),
    .cmd_ready(cmd_ready),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .position (position)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0;
  int done_cyc = 0;

  // Model of the active command: accepted at edge m_t0, starting from
  // Gray index m_ph0 (00,10,11,01 order) and position m_pos0.
  bit m_act = 1'b0;
  int m_t0 = 0;
  int m_n = 0;
  int m_dir = 0;
  int m_ph0 = 0;
  int m_pos0 = 0;

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  function automatic int gray(input int idx);
    case (idx)
      0: return 0;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int ph_idx(input int ab);
    case (ab)
      0: return 0;
      2: return 1;
      3: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int lp(input int v);
`ifdef QUADRATURE_GEN_POS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  function automatic int m_k(input int e);
    int k;
    if (!m_act || e < 0) return 0;
    k = e / S;
    if (k > 2 * m_n) k = 2 * m_n;
    return k;
  endfunction

  function automatic int m_ab(input int e);
    int k;
    k = m_k(e);
    if (m_dir != 0) return gray((m_ph0 + k) % 4);
    return gray((m_ph0 + 3 * k) % 4);
  endfunction

  function automatic int m_pos(input int e);
    int c;
    int p;
    c = (m_k(e) + 1) / 2;
    p = (m_dir != 0) ? m_pos0 + INC * c : m_pos0 - INC * c;
    return p & ((1 << W) - 1);
  endfunction

  function automatic bit m_busy(input int e);
    return m_act && (e <= 2 * m_n * S);
  endfunction

  // Model advance: accept whenever the model says the generator is idle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc    <= 0;
      m_act  <= 1'b0;
      m_t0   <= 0;
      m_n    <= 0;
      m_dir  <= 0;
      m_ph0  <= 0;
      m_pos0 <= 0;
    end else begin
      cyc <= cyc + 1;
      if (cmd_valid && !m_busy(cyc - m_t0)) begin
        m_ph0  <= ph_idx(m_ab(cyc - m_t0));
        m_pos0 <= m_pos(cyc - m_t0);
        m_act  <= 1'b1;
        m_t0   <= cyc + 1;
        m_n    <= int'(cmd_count);
        m_dir  <= int'(cmd_dir);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      int e;
      e = cyc - m_t0;
      chk("ab", int'({a, b}), m_ab(e));
      chk("position", int'(position), lp(m_pos(e)));
      chk("busy", int'(busy), int'(m_busy(e)));
      chk("cmd_ready", int'(cmd_ready), int'(!m_busy(e)));
      chk("done", int'(done), int'(m_act && e == 2 * m_n * S));
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic send(input bit d, input int n, output int tacc);
    int bnd;
    bnd = 0;
    @(negedge clk);
    cmd_dir   = d;
    cmd_count = W'(n);
    cmd_valid = 1'b1;
    while (!cmd_ready && bnd < 100) begin
      @(negedge clk);
      bnd++;
    end
    chk("accept_timeout", int'(bnd < 100), 1);
    @(posedge clk);
    #1;
    tacc      = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int bnd;
    bnd = 0;
    @(negedge clk);
    while (busy && bnd < 300) begin
      @(negedge clk);
      bnd++;
    end
    chk("idle_timeout", int'(bnd < 300), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t1;
    int t2;
    int bnd;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_count = '0;
    #1 reset = 1'b1;
    #1;
    chk("rst_ab", int'({a, b}), 0);
    chk("rst_pos", int'(position), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Up 3 from 00: ends at 11, done 24 edges after accept.
    done_cnt = 0;
    send(1'b1, 3, t);
    wait_idle();
    chk("t1_ab", int'({a, b}), 3);
    chk("t1_pos", int'(position), lp(3));
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_latency", done_cyc - t, 24);

    // Down 2 from 11: back to 11, position 1.
    send(1'b0, 2, t);
    wait_idle();
    chk("t2_ab", int'({a, b}), 3);
    chk("t2_pos", int'(position), lp(1));

    // Down 1 twice: 1 -> 0 -> 15 wrap.
    send(1'b0, 1, t);
    wait_idle();
    chk("t3a_ab", int'({a, b}), 0);
    chk("t3a_pos", int'(position), lp(0));
    send(1'b0, 1, t);
    wait_idle();
    chk("t3b_ab", int'({a, b}), 3);
    chk("t3b_pos", int'(position), lp(15));

    // Count 0: no toggles, done right after accept.
    done_cnt = 0;
    send(1'b1, 0, t);
    wait_idle();
    chk("t4_ab", int'({a, b}), 3);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_done_at", done_cyc - t, 0);
    chk("t4_pos", int'(position), lp(15));

    // Valid held with new data while busy: second accept 10 edges later.
    @(negedge clk);
    cmd_dir   = 1'b1;
    cmd_count = W'(1);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    t1        = cyc;
    cmd_dir   = 1'b0;
    cmd_count = W'(2);
    bnd = 0;
    @(negedge clk);
    while (!cmd_ready && bnd < 100) begin
      @(negedge clk);
      bnd++;
    end
    chk("t5_accept_timeout", int'(bnd < 100), 1);
    @(posedge clk);
    #1;
    t2        = cyc;
    cmd_valid = 1'b0;
    chk("t5_gap", t2 - t1, 10);
    wait_idle();
    chk("t5_ab", int'({a, b}), 0);
    chk("t5_pos", int'(position), lp(14));

    // Reset between the two transitions of a step.
    send(1'b1, 2, t);
    repeat (5) @(negedge clk);
    chk("t6_mid_ab", int'({a, b}), 2);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst_ab", int'({a, b}), 0);
    chk("t6_rst_pos", int'(position), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_ready", int'(cmd_ready), 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    send(1'b1, 1, t);
    wait_idle();
    chk("t6_ab", int'({a, b}), 3);
    chk("t6_pos", int'(position), lp(1));

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
